apu_sample_dma: RTL and testbench
=================================

Name: apu_sample_dma

Overview:
- Audio sample fetcher directly downstream of the SoC's APU control conduit and upstream of the audio output stage.
- On a control-word write, it reads a ring buffer of 64-bit stereo sample words out of HPS memory through the SoC's FPGA-side Avalon read conduit.
- Fetched words go into a small FIFO. One stereo frame (L/R, 16-bit each) is handed out per sample-rate request.
- Interrupts the CPU each time half of the ring has been fetched, so the CPU can refill that half.

Parameters:
- BUF_WORDS, 256: ring size in 64-bit words; power of two, >= 4.
- FIFO_DEPTH, 8: word FIFO depth; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ctrl_valid  in  1  one-cycle strobe: new control word.
- ctrl_data  in  32  [31:3] ring base byte address (8-byte aligned); [2:1] ignored; [0] enable.
- avm_addr  out  32  read byte address.
- avm_read  out  1  read request.
- avm_readdata  in  64  returned word.
- avm_readdatavalid  in  1  readdata valid.
- avm_waitrequest  in  1  slave stall.
- sample_req  in  1  one-cycle strobe from the output stage: advance one frame.
- sample_l  out  16  current left sample (signed).
- sample_r  out  16  current right sample (signed).
- half_irq  out  1  one-cycle pulse: a ring half has been fully fetched.
- half_idx  out  1  the half that finished (0 = lower, 1 = upper); valid with half_irq, held until the next pulse.
- underflow  out  1  sticky: a sample_req arrived while no frame was available.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; fetch pointer 0; enable 0.
- Word layout: [15:0] L0, [31:16] R0, [47:32] L1, [63:48] R1. Frame 0 is emitted first, then frame 1, then the word is popped.
- Read FSM has three states: IDLE, REQ, WAIT. Exactly one read is outstanding at a time.
- IDLE -> REQ: when enabled and (FIFO count + held-word flag) < FIFO_DEPTH. A word slot is always reserved before a read is issued.
- REQ: avm_read=1 and avm_addr = base + 8*ptr. Both are held stable while avm_waitrequest=1. Move to WAIT on the first cycle with avm_read=1 and avm_waitrequest=0.
- WAIT: on avm_readdatavalid, push avm_readdata into the FIFO (same-cycle push and pop is legal) and return to IDLE. A readdatavalid in any other state is ignored.
- Pointer: ptr increments by 1 on each accepted read (REQ with waitrequest low) and wraps to 0 after BUF_WORDS-1.
- half_irq pulses on the readdatavalid of the word at ptr BUF_WORDS/2-1 (half_idx=0) and of the word at ptr BUF_WORDS-1 (half_idx=1).
- Address arithmetic is 32-bit modulo; overflow is not checked.
- Control write with enable=1:
  - Latch base, clear underflow, set ptr=0, flush the FIFO and any held word.
  - If a read is outstanding (REQ already accepted, or WAIT), it completes and its data is discarded. Fetching then restarts from the new base.
  - A read still in REQ with waitrequest=1 is held until accepted, then discarded the same way. Avalon rules forbid dropping avm_read mid-stall.
- Control write with enable=0: same flush and discard rules; no new reads are issued; sample_l/sample_r are forced to 0 on the next cycle.
- Sample path:
  - On sample_req with a frame available, sample_l/sample_r are updated on the next edge (registered, latency 1).
  - With no frame available: outputs go to 0, underflow is set, and frame sequencing is unchanged.
  - sample_req while disabled outputs 0 and does not set underflow.
- Reset mid-transfer: everything returns to reset values immediately. Any late readdatavalid is ignored because the FSM is in IDLE.

Optional Feature:
- APU_SAMPLE_DMA_UFCNT_EN defined: adds output uf_count[15:0].
  - Saturating count of underflow events.
  - Cleared by reset and by any control write.
- Not defined: the port and counter are absent; underflow behaviour is otherwise identical.

Decomposition:
- Package apu_pkg holds:
  - typedef apu_frame_t (struct of signed 16-bit l and r);
  - enum dma_state_t (IDLE, REQ, WAIT);
  - constant APU_WORD_BYTES = 8.
- Sub-module apu_word_fifo: synchronous show-ahead FIFO of 64-bit words, parameter DEPTH, with push, pop, flush, count, empty, full.

Test Plan:
- Reset, then enable at base 0x1000_0000 with waitrequest=0 and data returning 2 cycles after each read -> avm_addr sequence 0x10000000, 0x10000008, …; reads stop when the FIFO is full (8 words, no sample_req).
- FIFO word 0x4444_3333_2222_1111, then two sample_req -> (L,R) = (0x1111, 0x2222), then (0x3333, 0x4444); the word is popped after the second request.
- BUF_WORDS=8, continuous sample_req -> half_irq with half_idx=0 on word 3, half_idx=1 on word 7; next address wraps back to base.
- Hold waitrequest=1 for 5 cycles during REQ -> avm_read and avm_addr stay stable; exactly one read is accepted.
- sample_req while the FIFO is empty and enabled -> samples go to 0 and underflow=1; the next control write clears it (uf_count=1, then 0, when APU_SAMPLE_DMA_UFCNT_EN is defined).
- Disable while in WAIT -> the late readdatavalid data is discarded, the FIFO stays empty, and no further avm_read is issued.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared types and constants for the APU sample fetcher.
package apu_pkg;

  // One stereo frame; l occupies the low half of each 32-bit slice of a word.
  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] l;
  } apu_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } dma_state_t;

  localparam logic [31:0] APU_WORD_BYTES = 32'd8;

  // Select frame 0 (low 32 bits) or frame 1 (high 32 bits) of a sample word.
  function automatic apu_frame_t word_frame(input logic [63:0] w, input logic sel);
    return sel ? apu_frame_t'(w[63:32]) : apu_frame_t'(w[31:0]);
  endfunction

endpackage

// File: rtl/apu_word_fifo.sv
// Synchronous show-ahead FIFO of 64-bit sample words with flush.
module apu_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [63:0]              data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [63:0]              data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/apu_sample_dma.sv
// Ring-buffer audio sample fetcher: Avalon reads into a word FIFO, one stereo
// frame out per sample request, half-ring interrupts.
// Optional: APU_SAMPLE_DMA_UFCNT_EN adds a saturating underflow counter uf_count.
module apu_sample_dma
  import apu_pkg::*;
#(
  parameter int unsigned BUF_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_data,
  output logic [31:0] avm_addr,
  output logic        avm_read,
  input  logic [63:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  input  logic        sample_req,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        half_irq,
  output logic        half_idx,
  output logic        underflow
`ifdef APU_SAMPLE_DMA_UFCNT_EN
  ,output logic [15:0] uf_count
`endif
);

  localparam int unsigned PW = $clog2(BUF_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_t    state_q, state_d;
  logic          enable_q;
  logic [31:0]   base_q;
  logic [31:0]   addr_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] req_ptr_q;
  logic          discard_q;
  logic          frame_sel_q;
  logic [15:0]   sample_l_q, sample_r_q;
  logic          half_irq_q, half_idx_q;
  logic          underflow_q;

  logic          accept;
  logic          data_in;
  logic          keep_data;
  logic          room;
  logic          have_frame;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [63:0]   fifo_data;
  logic [CW-1:0] fifo_count;
  apu_frame_t    cur_frame;
  logic          ctrl_unused;

  assign ctrl_unused = ^ctrl_data[2:1];

  assign accept     = (state_q == REQ) && !avm_waitrequest;
  assign data_in    = (state_q == WAIT) && avm_readdatavalid;
  assign keep_data  = data_in && !discard_q && !ctrl_valid;
  // The head word stays in the FIFO until both of its frames are consumed,
  // so the FIFO count already covers the partially-used word.
  assign room       = fifo_count < CW'(FIFO_DEPTH);
  assign have_frame = enable_q && !fifo_empty;
  assign fifo_push  = keep_data && !fifo_full;
  assign fifo_pop   = sample_req && !ctrl_valid && have_frame && frame_sel_q;
  assign cur_frame  = word_frame(fifo_data, frame_sel_q);

  apu_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (avm_readdata),
    .pop_i   (fifo_pop),
    .flush_i (ctrl_valid),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read FSM next state; a control write holds off new reads for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_q && !ctrl_valid && room) state_d = REQ;
      REQ:     if (!avm_waitrequest) state_d = WAIT;
      WAIT:    if (avm_readdatavalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs; the address is registered so it cannot move mid-stall.
  always_comb begin
    avm_read = (state_q == REQ);
    avm_addr = addr_q;
  end

  // Fetch control: base/pointer, request address capture, discard of stale reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q  <= 1'b0;
      base_q    <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      req_ptr_q <= '0;
      discard_q <= 1'b0;
    end else begin
      if (state_q == IDLE && state_d == REQ) begin
        addr_q    <= base_q + (32'(ptr_q) * APU_WORD_BYTES);
        req_ptr_q <= ptr_q;
      end
      if (ctrl_valid) begin
        enable_q  <= ctrl_data[0];
        if (ctrl_data[0]) base_q <= {ctrl_data[31:3], 3'b000};
        ptr_q     <= '0;
        // Any read already committed on the bus must still complete; mark it stale.
        discard_q <= (state_q == REQ) || (state_q == WAIT && !avm_readdatavalid);
      end else begin
        if (accept && !discard_q) ptr_q <= ptr_q + PW'(1);
        if (data_in) discard_q <= 1'b0;
      end
    end
  end

  // Sample path: registered frame output, frame sequencing and underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_l_q  <= '0;
      sample_r_q  <= '0;
      frame_sel_q <= 1'b0;
      underflow_q <= 1'b0;
    end else if (ctrl_valid) begin
      frame_sel_q <= 1'b0;
      underflow_q <= 1'b0;
      if (!ctrl_data[0]) begin
        sample_l_q <= '0;
        sample_r_q <= '0;
      end
    end else if (sample_req) begin
      if (have_frame) begin
        sample_l_q  <= cur_frame.l;
        sample_r_q  <= cur_frame.r;
        frame_sel_q <= ~frame_sel_q;
      end else begin
        sample_l_q <= '0;
        sample_r_q <= '0;
        if (enable_q) underflow_q <= 1'b1;
      end
    end
  end

  // Half-ring interrupt on arrival of the last word of either half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_irq_q <= 1'b0;
      half_idx_q <= 1'b0;
    end else begin
      half_irq_q <= 1'b0;
      if (keep_data && req_ptr_q == PW'(BUF_WORDS/2 - 1)) begin
        half_irq_q <= 1'b1;
        half_idx_q <= 1'b0;
      end else if (keep_data && req_ptr_q == PW'(BUF_WORDS - 1)) begin
        half_irq_q <= 1'b1;
        half_idx_q <= 1'b1;
      end
    end
  end

`ifdef APU_SAMPLE_DMA_UFCNT_EN
  logic [15:0] uf_count_q;

  // Saturating count of underflow events, cleared by any control write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_count_q <= '0;
    end else if (ctrl_valid) begin
      uf_count_q <= '0;
    end else if (sample_req && enable_q && fifo_empty && uf_count_q != '1) begin
      uf_count_q <= uf_count_q + 16'd1;
    end
  end

  assign uf_count = uf_count_q;
`endif

  assign sample_l  = sample_l_q;
  assign sample_r  = sample_r_q;
  assign half_irq  = half_irq_q;
  assign half_idx  = half_idx_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_apu_sample_dma.sv
// Directed bench for apu_sample_dma with an Avalon read-slave model.
module tb_apu_sample_dma;

  localparam int unsigned BUF_W  = 8;
  localparam int unsigned FDEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_valid = 1'b0;
  logic [31:0] ctrl_data = '0;
  logic [31:0] avm_addr;
  logic        avm_read;
  logic [63:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        sample_req = 1'b0;
  logic [15:0] sample_l, sample_r;
  logic        half_irq, half_idx, underflow;
`ifdef APU_SAMPLE_DMA_UFCNT_EN
  logic [15:0] uf_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat = 2;
  int          cyc = 0;
  logic [31:0] acc_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        irq_q[$];

  always #5 clk = ~clk;

  apu_sample_dma #(
    .BUF_WORDS  (BUF_W),
    .FIFO_DEPTH (FDEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ctrl_valid        (ctrl_valid),
    .ctrl_data         (ctrl_data),
    .avm_addr          (avm_addr),
    .avm_read          (avm_read),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest),
    .sample_req        (sample_req),
    .sample_l          (sample_l),
    .sample_r          (sample_r),
    .half_irq          (half_irq),
    .half_idx          (half_idx),
    .underflow         (underflow)
`ifdef APU_SAMPLE_DMA_UFCNT_EN
    , .uf_count        (uf_count)
`endif
  );

  // Memory contents: one distinctive word at 0x1000_0000, otherwise derived from the address.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [15:0] b;
    if (a == 32'h1000_0000) return 64'h4444_3333_2222_1111;
    b = {a[31:28], a[11:0]};
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    ctrl_data  = d;
    ctrl_valid = 1'b1;
    tick(1);
    ctrl_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] l, input logic [15:0] r);
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    chk({tag, "_l"}, 64'(sample_l), 64'(l));
    chk({tag, "_r"}, 64'(sample_r), 64'(r));
  endtask

  // Avalon slave: records accepted reads and returns data lat cycles later.
  always begin
    @(posedge clk);
    cyc++;
    if (avm_read && !avm_waitrequest) begin
      acc_q.push_back(avm_addr);
      pend_addr.push_back(avm_addr);
      pend_due.push_back(cyc + lat);
    end
    #1;
    if (pend_due.size() > 0 && pend_due[0] == cyc + 1) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
    end
  end

  // Interrupt log.
  always @(posedge clk) begin
    if (half_irq) irq_q.push_back(half_idx);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] eb;
    int          n0;
    int          k;

    // Reset values
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_read", 64'(avm_read), 64'd0);
    chk("rst_addr", 64'(avm_addr), 64'd0);
    chk("rst_l", 64'(sample_l), 64'd0);
    chk("rst_r", 64'(sample_r), 64'd0);
    chk("rst_irq", 64'(half_irq), 64'd0);
    chk("rst_idx", 64'(half_idx), 64'd0);
    chk("rst_uf", 64'(underflow), 64'd0);
`ifdef APU_SAMPLE_DMA_UFCNT_EN
    chk("rst_ufcnt", 64'(uf_count), 64'd0);
`endif

    // Fill: 8 sequential reads then stop on full FIFO
    ctrl_write(32'h1000_0001);
    tick(80);
    chk("fill_reads", 64'(acc_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("fill_addr", 64'(acc_q[i]), 64'(32'h1000_0000 + 32'(8 * i)));
    chk("fill_stop", 64'(avm_read), 64'd0);
    chk("irq_cnt_a", 64'(irq_q.size()), 64'd2);
    chk("irq_idx0", 64'(irq_q[0]), 64'd0);
    chk("irq_idx1", 64'(irq_q[1]), 64'd1);

    // Word unpacking and streaming, with ring wrap
    check_frame("w0f0", 16'h1111, 16'h2222);
    check_frame("w0f1", 16'h3333, 16'h4444);
    for (int w = 1; w < 8; w++) begin
      for (int f = 0; f < 2; f++) begin
        tick(2);
        eb = 16'h1000 + 16'(8 * w) + 16'(2 * f);
        check_frame("stream", eb, eb + 16'd1);
      end
    end
    tick(80);
    chk("stream_reads", 64'(acc_q.size()), 64'd16);
    chk("wrap_addr", 64'(acc_q[8]), 64'h1000_0000);
    chk("last_addr", 64'(acc_q[15]), 64'h1000_0038);
    chk("irq_cnt_b", 64'(irq_q.size()), 64'd4);
    chk("irq_idx2", 64'(irq_q[2]), 64'd0);
    chk("irq_idx3", 64'(irq_q[3]), 64'd1);

    // Waitrequest stall holds the request stable
    avm_waitrequest = 1'b1;
    check_frame("d_f0", 16'h1111, 16'h2222);
    check_frame("d_f1", 16'h3333, 16'h4444);
    k = 0;
    while (!avm_read && k < 20) begin
      tick(1);
      k++;
    end
    chk("stall_seen", 64'(avm_read), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_read", 64'(avm_read), 64'd1);
      chk("stall_addr", 64'(avm_addr), 64'h1000_0000);
      tick(1);
    end
    avm_waitrequest = 1'b0;
    tick(20);
    chk("stall_one", 64'(acc_q.size()), 64'd17);

    // Underflow, clearing by control write, stalled read discarded
    avm_waitrequest = 1'b1;
    ctrl_write(32'h2000_0001);
    tick(3);
    check_frame("uf", 16'h0000, 16'h0000);
    chk("uf_flag", 64'(underflow), 64'd1);
`ifdef APU_SAMPLE_DMA_UFCNT_EN
    chk("uf_cnt1", 64'(uf_count), 64'd1);
`endif
    ctrl_write(32'h3000_0001);
    chk("uf_clr", 64'(underflow), 64'd0);
`ifdef APU_SAMPLE_DMA_UFCNT_EN
    chk("uf_cnt0", 64'(uf_count), 64'd0);
`endif
    chk("hold_read", 64'(avm_read), 64'd1);
    chk("hold_addr", 64'(avm_addr), 64'h2000_0000);
    avm_waitrequest = 1'b0;
    tick(60);
    check_frame("nb_f0", 16'h3000, 16'h3001);
    chk("disc_addr", 64'(acc_q[17]), 64'h2000_0000);
    chk("new_addr", 64'(acc_q[18]), 64'h3000_0000);

    // Disable while a read is in WAIT
    lat = 6;
    n0 = acc_q.size();
    check_frame("f_f1", 16'h3002, 16'h3003);
    k = 0;
    while (acc_q.size() == n0 && k < 20) begin
      tick(1);
      k++;
    end
    chk("f_acc", 64'(acc_q.size()), 64'(n0 + 1));
    ctrl_write(32'h0000_0000);
    chk("dis_l", 64'(sample_l), 64'd0);
    chk("dis_r", 64'(sample_r), 64'd0);
    tick(30);
    chk("dis_reads", 64'(acc_q.size()), 64'(n0 + 1));
    chk("dis_read", 64'(avm_read), 64'd0);
    check_frame("dis_req", 16'h0000, 16'h0000);
    chk("dis_no_uf", 64'(underflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
